// File: rtl/counter_tmr_down_if.sv
`default_nettype none
// ============================================================================
// Module   : counter_tmr_down_if
// Purpose  : Control/status bundle for the minutes:seconds countdown timer.
//            The "master" side drives the controls and presets; the "slave"
//            side (the timer) returns the count and status flags.
// Signals  : i_Tick, i_Load, i_Min_Set[DW], i_Sec_Set[DW], i_Start_Stop,
//            i_Clear                                  (master -> slave)
//            o_sec[DW], o_min[DW], o_running, o_borrow,
//            o_expire, o_done                         (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface counter_tmr_down_if #(
  parameter int DW = 6
);
  logic          i_Tick;
  logic          i_Load;
  logic [DW-1:0] i_Min_Set;
  logic [DW-1:0] i_Sec_Set;
  logic          i_Start_Stop;
  logic          i_Clear;
  logic [DW-1:0] o_sec;
  logic [DW-1:0] o_min;
  logic          o_running;
  logic          o_borrow;
  logic          o_expire;
  logic          o_done;

  modport master (
    output i_Tick, i_Load, i_Min_Set, i_Sec_Set, i_Start_Stop, i_Clear,
    input  o_sec, o_min, o_running, o_borrow, o_expire, o_done
  );

  modport slave (
    input  i_Tick, i_Load, i_Min_Set, i_Sec_Set, i_Start_Stop, i_Clear,
    output o_sec, o_min, o_running, o_borrow, o_expire, o_done
  );
endinterface
`default_nettype wire

// File: rtl/counter_tmr_down.sv
`default_nettype none
// ============================================================================
// Module   : counter_tmr_down
// Purpose  : Minutes:seconds countdown timer. Loads a (saturated) preset,
//            decrements once per 1 Hz tick while running, and flags expiry
//            when 00:00 is reached. All outputs are registered.
// Ports    : clk  - system clock
//            rst  - asynchronous, active-low reset
//            bus  - counter_tmr_down_if.slave (controls, presets, count,
//                   running/borrow/expire/done flags)
// Revision : 1.0 - initial release
// ============================================================================
module counter_tmr_down #(
  parameter int SEC_LIMIT = 60,
  parameter int MIN_LIMIT = 60,
  parameter int DW        = 6
) (
  input  wire                     clk,
  input  wire                     rst,
  counter_tmr_down_if.slave       bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [DW-1:0] c_SEC_MAX = DW'(SEC_LIMIT - 1);
  localparam logic [DW-1:0] c_MIN_MAX = DW'(MIN_LIMIT - 1);
  localparam logic [DW-1:0] c_ZERO    = '0;
  localparam logic [DW-1:0] c_ONE     = DW'(1);

  logic [1:0]    r_state;
  logic [DW-1:0] r_sec;
  logic [DW-1:0] r_min;
  logic          r_borrow;
  logic          r_expire;

  logic [1:0]    w_state_nxt;
  logic [DW-1:0] w_sec_nxt;
  logic [DW-1:0] w_min_nxt;
  logic          w_borrow_nxt;
  logic          w_expire_nxt;
  logic          w_is_zero;

  assign w_is_zero = (r_sec == c_ZERO) && (r_min == c_ZERO);

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_sec    <= c_ZERO;
      r_min    <= c_ZERO;
      r_borrow <= 1'b0;
      r_expire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_sec    <= w_sec_nxt;
      r_min    <= w_min_nxt;
      r_borrow <= w_borrow_nxt;
      r_expire <= w_expire_nxt;
    end
  end

  // Next-state / next-count logic. Clear beats load beats FSM activity;
  // pulses default low so they last exactly one clk.
  always_comb begin
    w_state_nxt  = r_state;
    w_sec_nxt    = r_sec;
    w_min_nxt    = r_min;
    w_borrow_nxt = 1'b0;
    w_expire_nxt = 1'b0;

    if (bus.i_Clear) begin
      w_state_nxt = S_IDLE;
      w_sec_nxt   = c_ZERO;
      w_min_nxt   = c_ZERO;
    end else if (bus.i_Load) begin
      w_state_nxt = S_IDLE;
      w_min_nxt   = (bus.i_Min_Set > c_MIN_MAX) ? c_MIN_MAX : bus.i_Min_Set;
      w_sec_nxt   = (bus.i_Sec_Set > c_SEC_MAX) ? c_SEC_MAX : bus.i_Sec_Set;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Starting from 00:00 is a no-op: nothing to count down.
          if (bus.i_Start_Stop && !w_is_zero) begin
            w_state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          // Stopping takes precedence over a coincident tick.
          if (!bus.i_Start_Stop) begin
            w_state_nxt = S_HOLD;
          end else if (bus.i_Tick) begin
            if (r_sec != c_ZERO) begin
              w_sec_nxt = r_sec - c_ONE;
              if ((r_sec == c_ONE) && (r_min == c_ZERO)) begin
                w_state_nxt  = S_DONE;
                w_expire_nxt = 1'b1;
              end
            end else if (r_min != c_ZERO) begin
              w_sec_nxt    = c_SEC_MAX;
              w_min_nxt    = r_min - c_ONE;
              w_borrow_nxt = 1'b1;
            end
          end
        end
        S_HOLD: begin
          // Ticks are ignored here, including one in the resume cycle.
          if (bus.i_Start_Stop) begin
            w_state_nxt = S_RUN;
          end
        end
        S_DONE: begin
          w_state_nxt = S_DONE;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Outputs decoded straight from registers only
  always_comb begin
    bus.o_sec     = r_sec;
    bus.o_min     = r_min;
    bus.o_running = (r_state == S_RUN);
    bus.o_done    = (r_state == S_DONE);
    bus.o_borrow  = r_borrow;
    bus.o_expire  = r_expire;
  end

endmodule
`default_nettype wire

// File: tb/tb_counter_tmr_down.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_tmr_down
// Purpose  : Directed self-checking bench for counter_tmr_down.
// Revision : 1.0 - initial release
// ============================================================================
module tb_counter_tmr_down;

  localparam int DW = 6;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  counter_tmr_down_if #(.DW(DW)) u_if ();

  counter_tmr_down #(
    .SEC_LIMIT (60),
    .MIN_LIMIT (60),
    .DW        (DW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clk; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int mn, input int sc,
                           input bit run, input bit brw, input bit exq, input bit dn);
    check({tag, ".min"},     32'(u_if.o_min),     32'(mn));
    check({tag, ".sec"},     32'(u_if.o_sec),     32'(sc));
    check({tag, ".running"}, 32'(u_if.o_running), 32'(run));
    check({tag, ".borrow"},  32'(u_if.o_borrow),  32'(brw));
    check({tag, ".expire"},  32'(u_if.o_expire),  32'(exq));
    check({tag, ".done"},    32'(u_if.o_done),    32'(dn));
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    u_if.i_Tick = 1'b0;
    u_if.i_Load = 1'b0;
    u_if.i_Min_Set = '0;
    u_if.i_Sec_Set = '0;
    u_if.i_Start_Stop = 1'b0;
    u_if.i_Clear = 1'b0;

    // Reset held for 3 clk with random ticks, then idle with random ticks
    for (int i = 0; i < 3; i++) begin
      u_if.i_Tick = 1'($urandom_range(0, 1));
      step();
      check_all("reset", 0, 0, 0, 0, 0, 0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.i_Tick = 1'($urandom_range(0, 1));
      step();
      check_all("idle", 0, 0, 0, 0, 0, 0);
    end
    u_if.i_Tick = 1'b0;

    // Load 01:02 and count down
    u_if.i_Load = 1'b1; u_if.i_Min_Set = 6'd1; u_if.i_Sec_Set = 6'd2;
    step();
    u_if.i_Load = 1'b0;
    check_all("load_0102", 1, 2, 0, 0, 0, 0);
    u_if.i_Start_Stop = 1'b1;
    step();
    check_all("start", 1, 2, 1, 0, 0, 0);
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("tick1", 1, 1, 1, 0, 0, 0);
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("tick2", 1, 0, 1, 0, 0, 0);
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("tick3_borrow", 0, 59, 1, 1, 0, 0);
    step();
    check_all("borrow_one_clk", 0, 59, 1, 0, 0, 0);
    for (int i = 0; i < 58; i++) begin
      u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
      step();
    end
    check_all("at_0001", 0, 1, 1, 0, 0, 0);
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("expire", 0, 0, 0, 0, 1, 1);
    step();
    check_all("expire_one_clk", 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    end
    check_all("done_extra_ticks", 0, 0, 0, 0, 0, 1);

    // Hold / resume at 00:10 (Start_Stop stays high through the load)
    u_if.i_Load = 1'b1; u_if.i_Min_Set = 6'd0; u_if.i_Sec_Set = 6'd10;
    step();
    u_if.i_Load = 1'b0;
    check_all("load_0010", 0, 10, 0, 0, 0, 0);
    step();
    check_all("run_0010", 0, 10, 1, 0, 0, 0);
    u_if.i_Tick = 1'b1; u_if.i_Start_Stop = 1'b0;
    step();
    u_if.i_Tick = 1'b0;
    check_all("hold_entry", 0, 10, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    end
    check_all("hold_ticks", 0, 10, 0, 0, 0, 0);
    u_if.i_Start_Stop = 1'b1; u_if.i_Tick = 1'b1;
    step();
    u_if.i_Tick = 1'b0;
    check_all("resume", 0, 10, 1, 0, 0, 0);
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("resume_tick", 0, 9, 1, 0, 0, 0);

    // Saturating load, then 00:00 start attempt
    u_if.i_Start_Stop = 1'b0;
    u_if.i_Load = 1'b1; u_if.i_Min_Set = 6'd63; u_if.i_Sec_Set = 6'd61;
    step();
    u_if.i_Load = 1'b0;
    check_all("sat_load", 59, 59, 0, 0, 0, 0);
    u_if.i_Load = 1'b1; u_if.i_Min_Set = 6'd0; u_if.i_Sec_Set = 6'd0;
    u_if.i_Start_Stop = 1'b1;
    step();
    u_if.i_Load = 1'b0;
    check_all("load_zero", 0, 0, 0, 0, 0, 0);
    step();
    check_all("start_at_zero", 0, 0, 0, 0, 0, 0);
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("zero_stays_idle", 0, 0, 0, 0, 0, 0);

    // Priority: clear over load over tick, then load over tick
    u_if.i_Load = 1'b1; u_if.i_Min_Set = 6'd12; u_if.i_Sec_Set = 6'd34;
    step();
    u_if.i_Load = 1'b0;
    step();
    check_all("prio_run", 12, 34, 1, 0, 0, 0);
    u_if.i_Clear = 1'b1; u_if.i_Load = 1'b1; u_if.i_Tick = 1'b1;
    u_if.i_Min_Set = 6'd5; u_if.i_Sec_Set = 6'd5;
    step();
    u_if.i_Clear = 1'b0;
    check_all("prio_clear", 0, 0, 0, 0, 0, 0);
    step();
    u_if.i_Load = 1'b0; u_if.i_Tick = 1'b0;
    check_all("prio_load", 5, 5, 0, 0, 0, 0);

    // Async reset mid-run at 12:34
    u_if.i_Load = 1'b1; u_if.i_Min_Set = 6'd12; u_if.i_Sec_Set = 6'd34;
    step();
    u_if.i_Load = 1'b0;
    step();
    u_if.i_Tick = 1'b1; step(); u_if.i_Tick = 1'b0;
    check_all("pre_reset", 12, 33, 1, 0, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    check_all("async_reset", 0, 0, 0, 0, 0, 0);
    u_if.i_Start_Stop = 1'b0;
    step();
    #3;
    rst = 1'b1;
    step();
    check_all("post_reset", 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/counter_tmr_down.md
Name: counter_tmr_down

Overview:
Minutes:seconds countdown timer. It is the down-counting counterpart of the stopwatch up-counters in the same clock/timer subsystem. The timer loads a preset, decrements once per 1 Hz tick while running, and flags expiry at 00:00. Outputs feed the same 7-segment display mux as the stopwatch digits.

Parameters:
SEC_LIMIT, 60, seconds modulus; seconds range 0..SEC_LIMIT-1
MIN_LIMIT, 60, minutes modulus; minutes range 0..MIN_LIMIT-1
DW, 6, width of the minutes and seconds fields; must satisfy 2^DW >= max(SEC_LIMIT, MIN_LIMIT)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset
i_Tick  input  1  1 Hz enable strobe, one clk wide
i_Load  input  1  load the preset (level sampled each clk)
i_Min_Set  input  DW  preset minutes
i_Sec_Set  input  DW  preset seconds
i_Start_Stop  input  1  level; 1 = run, 0 = hold
i_Clear  input  1  synchronous clear to 00:00 and IDLE
o_sec  output  DW  current seconds
o_min  output  DW  current minutes
o_running  output  1  high while in RUN
o_borrow  output  1  one-clk pulse when seconds wrap 0 -> SEC_LIMIT-1
o_expire  output  1  one-clk pulse on the cycle DONE is entered
o_done  output  1  level, high while in DONE

Behaviour:
- Reset (rst=0, async): o_sec=0, o_min=0, state=IDLE; o_running, o_borrow, o_expire and o_done are all 0.
- All outputs are registered. A value change is visible the clk after the sampled event.
- Synchronous priority, highest first: i_Clear > i_Load > state/tick logic.
- i_Clear: count goes to 00:00, state goes to IDLE, pulses go to 0. This applies in any state.
- i_Load: o_min=min(i_Min_Set, MIN_LIMIT-1) and o_sec=min(i_Sec_Set, SEC_LIMIT-1), i.e. out-of-range presets saturate. State goes to IDLE. Load is honoured in any state. A tick in the same cycle is ignored.
- FSM states:
  - IDLE:
    - i_Start_Stop=1 with count != 00:00 -> RUN.
    - i_Start_Stop=1 with count == 00:00 -> stay in IDLE. No expire pulse.
  - RUN:
    - i_Start_Stop=0 -> HOLD. A tick in that same cycle is NOT applied.
    - Otherwise, on i_Tick, decrement as follows:
      - sec>0: sec-1.
      - sec==0 and min>0: sec=SEC_LIMIT-1, min-1, o_borrow=1 for one clk.
      - Any decrement producing 00:00 -> DONE, with o_expire=1 for one clk.
  - HOLD:
    - Count frozen; ticks ignored.
    - i_Start_Stop=1 -> RUN. Decrementing resumes on the next tick after entry; a tick in the transition cycle is ignored.
  - DONE:
    - Count held at 00:00; o_done=1; i_Start_Stop and i_Tick ignored.
    - Exit only via i_Clear or i_Load.
- o_running = (state==RUN); o_done = (state==DONE).
- o_borrow and o_expire are never high for more than one clk. They may be high in the same clk only if the borrow lands on 00:00, which is impossible because a borrow sets sec=SEC_LIMIT-1.
- Minutes never wrap: 00:00 is terminal.
- Arithmetic is on unsigned DW-bit fields; no intermediate overflow is possible.
- Reset asserted mid-count returns the block to the reset values immediately, independent of clk.

Test Plan:
- Reset then idle: rst low for 3 clk, then high, with random ticks -> o_min=0, o_sec=0, o_running=0, o_done=0 throughout.
- Load and countdown: load 01:02, Start_Stop=1, 3 ticks:
  - tick 1 -> 01:01; tick 2 -> 01:00; tick 3 -> 00:59 with o_borrow=1 for exactly one clk.
  - 59 further ticks -> 00:00, o_expire for one clk, o_done=1, o_running=0.
  - Extra ticks leave the count at 00:00.
- Hold/resume: at 00:10 running, drop Start_Stop on the same cycle as a tick -> count stays 00:10 in HOLD across 5 ticks. Raise Start_Stop -> next tick gives 00:09.
- Saturating load: load i_Min_Set=63, i_Sec_Set=61 -> 59:59. Load 00:00 with Start_Stop=1 -> stays IDLE, no o_expire.
- Priority: assert i_Clear, i_Load (05:05) and i_Tick in one RUN cycle -> 00:00, IDLE. Next cycle, Load and Tick together -> 05:05, IDLE, no decrement.
- Async reset mid-run: pull rst low between clk edges at 12:34 -> outputs read 00:00 and flags 0 before the next edge. Release -> IDLE.
